// File: rtl/video_frame_sequencer_pkg.sv
// Shared types for the frame sequencer: sequencer states and the RGB pixel word.
package video_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        STREAM    = 2'd2
    } seq_state_e;

    // Pixel as it travels through the output buffer, tagged with its frame position.
    typedef struct packed {
        logic sof;
        logic eof;
        rgb_t rgb;
    } pix_word_t;

endpackage

// File: rtl/video_frame_sequencer_if.sv
// Frame-memory read port plus the valid/ready pixel stream of the sequencer.
interface video_frame_sequencer_if
    import video_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    rgb_t              mem_data;
    rgb_t              pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sof;
    logic              pix_eof;

    modport master (
        output mem_rd, mem_addr, pix_data, pix_valid, pix_sof, pix_eof,
        input  mem_data, pix_ready
    );

    modport slave (
        input  mem_rd, mem_addr, pix_data, pix_valid, pix_sof, pix_eof,
        output mem_data, pix_ready
    );
endinterface

// File: rtl/video_frame_sequencer_pix_skid_fifo.sv
// Two-entry FIFO between the memory return path and the pixel stream output.
module pix_skid_fifo #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);
    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // A push never lands in the head slot while it is occupied, so the head holds during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= din_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout_o  = slot_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/video_frame_sequencer.sv
// Plays frames out of frame memory one pixel per cycle, one frame per frame_tick.
module video_frame_sequencer
    import video_pkg::*;
#(
    parameter  int N_FRAMES     = 24,
    parameter  int FRAME_PIXELS = 2048,
    localparam int TOTAL_PIXELS = N_FRAMES * FRAME_PIXELS,
    localparam int ADDR_W       = $clog2(TOTAL_PIXELS),
    localparam int FRAME_W      = $clog2(N_FRAMES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    input  logic                    frame_tick,
    video_frame_sequencer_if.master bus,
    output logic [FRAME_W-1:0]      frame_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);
    localparam int                  PCNT_W     = $clog2(FRAME_PIXELS + 1);
    localparam logic [PCNT_W-1:0]   PIX_END    = PCNT_W'(FRAME_PIXELS);
    localparam logic [PCNT_W-1:0]   PIX_LAST   = PCNT_W'(FRAME_PIXELS - 1);
    localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(N_FRAMES - 1);
    localparam logic [ADDR_W-1:0]   FRAME_STEP = ADDR_W'(FRAME_PIXELS);

    seq_state_e          state_q, state_d;
    logic [FRAME_W-1:0]  frame_idx_q, frame_idx_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                mem_rd_q, mem_rd_d;
    logic                tag_sof_q, tag_sof_d;
    logic                tag_eof_q, tag_eof_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    pix_word_t           fifo_din;
    pix_word_t           fifo_dout;
    logic                fifo_valid;
    logic [1:0]          fifo_count;
    logic                fifo_push;
    logic                pix_pop;
    logic                frame_end;
    logic [2:0]          occupancy;
    logic                room;
    logic                issue;

    // A read on the bus this cycle is captured at the next edge, so it already holds a FIFO slot.
    assign pix_pop   = fifo_valid && bus.pix_ready;
    assign frame_end = pix_pop && fifo_dout.eof;
    assign occupancy = {1'b0, fifo_count} + {2'b00, mem_rd_q};
    assign room      = occupancy < (3'd2 + {2'b00, pix_pop});
    assign issue     = (state_q == STREAM) && (pix_cnt_q < PIX_END) && room && !stop;
    assign fifo_push = mem_rd_q && !stop;
    assign fifo_din  = '{sof: tag_sof_q, eof: tag_eof_q, rgb: bus.mem_data};

    pix_skid_fifo #(
        .WIDTH(PIXEL_W + 2)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (fifo_push),
        .pop_i  (pix_pop),
        .flush_i(stop),
        .din_i  (fifo_din),
        .dout_o (fifo_dout),
        .valid_o(fifo_valid),
        .count_o(fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_idx_q <= '0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            pix_cnt_q   <= '0;
            mem_rd_q    <= 1'b0;
            tag_sof_q   <= 1'b0;
            tag_eof_q   <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_idx_q <= frame_idx_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            pix_cnt_q   <= pix_cnt_d;
            mem_rd_q    <= mem_rd_d;
            tag_sof_q   <= tag_sof_d;
            tag_eof_q   <= tag_eof_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_idx_d = frame_idx_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        pix_cnt_d   = pix_cnt_q;
        mem_rd_d    = 1'b0;
        tag_sof_d   = tag_sof_q;
        tag_eof_d   = tag_eof_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        // The frame base advances by addition, so the address needs no multiplier.
        if (issue) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = base_q + ADDR_W'(pix_cnt_q);
            pix_cnt_d  = pix_cnt_q + PCNT_W'(1);
            tag_sof_d  = (pix_cnt_q == '0);
            tag_eof_d  = (pix_cnt_q == PIX_LAST);
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d     = WAIT_TICK;
                    frame_idx_d = '0;
                    base_d      = '0;
                    overrun_d   = 1'b0;
                end
            end
            WAIT_TICK: begin
                if (frame_tick) begin
                    state_d   = STREAM;
                    pix_cnt_d = '0;
                end
            end
            STREAM: begin
                if (frame_tick) begin
                    overrun_d = 1'b1;
                end
                if (frame_end) begin
                    if (frame_idx_q < FRAME_LAST) begin
                        frame_idx_d = frame_idx_q + FRAME_W'(1);
                        base_d      = base_q + FRAME_STEP;
                        state_d     = WAIT_TICK;
                    end else if (loop_en) begin
                        frame_idx_d = '0;
                        base_d      = '0;
                        state_d     = WAIT_TICK;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d  = IDLE;
            mem_rd_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.pix_data  = fifo_dout.rgb;
    assign bus.pix_valid = fifo_valid;
    assign bus.pix_sof   = fifo_dout.sof;
    assign bus.pix_eof   = fifo_dout.eof;
    assign frame_idx     = frame_idx_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_video_frame_sequencer.sv
// Scoreboard bench for video_frame_sequencer with 3 frames of 4 pixels.
module tb_video_frame_sequencer;
    import video_pkg::*;

    localparam int NF = 3;
    localparam int FP = 4;
    localparam int AW = 4;
    localparam int FW = 2;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [23:0] data;
    } exp_pix_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          loop_en    = 1'b0;
    logic          frame_tick = 1'b0;
    logic [FW-1:0] frame_idx;
    logic          busy;
    logic          done;
    logic          overrun;

    video_frame_sequencer_if #(.ADDR_W(AW)) bus();

    video_frame_sequencer #(
        .N_FRAMES    (NF),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .frame_tick(frame_tick),
        .bus       (bus),
        .frame_idx (frame_idx),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    exp_pix_t       expPixQ[$];
    logic [AW-1:0]  expAddrQ[$];
    int             errors    = 0;
    int             checks    = 0;
    int             doneCount = 0;
    int             issued    = 0;
    int             popped    = 0;
    logic           stallPending = 1'b0;
    exp_pix_t       heldPix;
    exp_pix_t       monGot;
    exp_pix_t       monExp;
    logic [3:0]     readyPat  = 4'b1001;

    function automatic logic [23:0] memWord(input logic [AW-1:0] a);
        return {a, 4'h5, ~a, 4'hC, a, 4'h3};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tickClk();
        @(posedge clk);
        #1;
    endtask

    // Memory returns the addressed word on the falling edge of the issuing cycle.
    always @(negedge clk) begin
        if (!rst_n) bus.mem_data <= '0;
        else if (bus.mem_rd) bus.mem_data <= memWord(bus.mem_addr);
    end

    // Monitor: pops expected reads and pixels as the DUT presents them.
    always @(negedge clk) begin
        if (done) doneCount++;
        if (!rst_n || !busy) begin
            issued       = 0;
            popped       = 0;
            stallPending = 1'b0;
        end else begin
            if (bus.mem_rd) begin
                issued++;
                if (expAddrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL mem_addr: got read at 0x%0h, expected no read", bus.mem_addr);
                end else begin
                    checkOutput("mem_addr", 32'(bus.mem_addr), 32'(expAddrQ.pop_front()));
                end
                checkOutput("reads_ahead_le2", 32'((issued - popped) <= 2), 32'd1);
            end
            monGot = {bus.pix_sof, bus.pix_eof, bus.pix_data};
            if (stallPending) begin
                checkOutput("stall_valid", 32'(bus.pix_valid), 32'd1);
                checkOutput("stall_hold", 32'(monGot), 32'(heldPix));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                popped++;
                if (expPixQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pixel: got 0x%0h, expected no pixel", monGot);
                end else begin
                    monExp = expPixQ.pop_front();
                    checkOutput("pixel", 32'(monGot), 32'(monExp));
                end
            end
            stallPending = bus.pix_valid && !bus.pix_ready;
            heldPix      = monGot;
        end
    end

    // Queue one frame's reads and pixels, then pulse frame_tick for one cycle.
    task automatic applyStimulus(input int base);
        exp_pix_t p;
        for (int i = 0; i < FP; i++) begin
            expAddrQ.push_back(AW'(base + i));
            p.sof  = (i == 0);
            p.eof  = (i == FP - 1);
            p.data = memWord(AW'(base + i));
            expPixQ.push_back(p);
        end
        frame_tick = 1'b1;
        tickClk();
        frame_tick = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tickClk();
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        tickClk();
        stop = 1'b0;
    endtask

    task automatic waitDrain(input bit bp);
        int i;
        for (i = 0; i < 200; i++) begin
            if (expPixQ.size() == 0 && expAddrQ.size() == 0) break;
            bus.pix_ready = bp ? readyPat[3 - (i % 4)] : 1'b1;
            tickClk();
        end
        bus.pix_ready = 1'b1;
        if (i == 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pixels left, expected 0", expPixQ.size());
            expPixQ.delete();
            expAddrQ.delete();
        end
    endtask

    task automatic checkBurst(input int base);
        for (int w = 0; w < 10 && !bus.mem_rd; w++) tickClk();
        for (int i = 0; i < FP; i++) begin
            checkOutput("burst_rd", 32'(bus.mem_rd), 32'd1);
            checkOutput("burst_addr", 32'(bus.mem_addr), 32'(base + i));
            tickClk();
        end
        checkOutput("burst_end_rd", 32'(bus.mem_rd), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_rd"},    32'(bus.mem_rd),    32'd0);
        checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        checkOutput({tag, "_pix_data"},  32'(bus.pix_data),  32'd0);
        checkOutput({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
        checkOutput({tag, "_pix_sof"},   32'(bus.pix_sof),   32'd0);
        checkOutput({tag, "_pix_eof"},   32'(bus.pix_eof),   32'd0);
        checkOutput({tag, "_frame_idx"}, 32'(frame_idx),     32'd0);
        checkOutput({tag, "_busy"},      32'(busy),          32'd0);
        checkOutput({tag, "_done"},      32'(done),          32'd0);
        checkOutput({tag, "_overrun"},   32'(overrun),       32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        bus.pix_ready = 1'b1;

        // Reset state
        #2 rst_n = 1'b0;
        #2 checkAllZero("reset");
        repeat (2) tickClk();
        rst_n = 1'b1;
        tickClk();

        // Single frame at full rate
        pulseStart();
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_frame_idx", 32'(frame_idx), 32'd0);
        applyStimulus(0);
        checkBurst(0);
        waitDrain(1'b0);
        checkOutput("f0_frame_idx", 32'(frame_idx), 32'd1);

        // Rest of non-looped playback
        applyStimulus(4);
        waitDrain(1'b0);
        applyStimulus(8);
        waitDrain(1'b0);
        repeat (2) tickClk();
        checkOutput("play_done_count", 32'(doneCount), 32'd1);
        checkOutput("play_busy", 32'(busy), 32'd0);
        checkOutput("play_frame_idx", 32'(frame_idx), 32'd2);

        // Looped playback: fourth frame rereads frame 0
        loop_en = 1'b1;
        pulseStart();
        applyStimulus(0);
        waitDrain(1'b0);
        applyStimulus(4);
        waitDrain(1'b0);
        applyStimulus(8);
        waitDrain(1'b0);
        checkOutput("loop_wrap_idx", 32'(frame_idx), 32'd0);
        applyStimulus(0);
        waitDrain(1'b0);
        repeat (2) tickClk();
        checkOutput("loop_done_count", 32'(doneCount), 32'd1);
        checkOutput("loop_busy", 32'(busy), 32'd1);
        checkOutput("loop_frame_idx", 32'(frame_idx), 32'd1);
        pulseStop();
        tickClk();
        checkOutput("loop_stop_busy", 32'(busy), 32'd0);
        checkOutput("loop_stop_done", 32'(doneCount), 32'd1);
        loop_en = 1'b0;

        // Backpressure with ready pattern 1,0,0,1
        pulseStart();
        applyStimulus(0);
        waitDrain(1'b1);
        applyStimulus(4);
        waitDrain(1'b1);
        checkOutput("bp_frame_idx", 32'(frame_idx), 32'd2);
        pulseStop();

        // Stop mid-frame after address 1, then replay
        pulseStart();
        applyStimulus(0);
        for (w = 0; w < 10; w++) begin
            if (bus.mem_rd && bus.mem_addr == AW'(1)) break;
            tickClk();
        end
        checkOutput("stop_saw_addr1", 32'(w < 10), 32'd1);
        pulseStop();
        checkOutput("stop_busy", 32'(busy), 32'd0);
        checkOutput("stop_pix_valid", 32'(bus.pix_valid), 32'd0);
        checkOutput("stop_mem_rd", 32'(bus.mem_rd), 32'd0);
        expPixQ.delete();
        expAddrQ.delete();
        repeat (2) tickClk();
        checkOutput("stop_no_done", 32'(doneCount), 32'd1);
        pulseStart();
        applyStimulus(0);
        checkBurst(0);
        waitDrain(1'b0);
        checkOutput("replay_frame_idx", 32'(frame_idx), 32'd1);

        // Overrun: tick while streaming; start ignored while busy
        checkOutput("ovr_clear", 32'(overrun), 32'd0);
        applyStimulus(4);
        tickClk();
        frame_tick = 1'b1;
        tickClk();
        frame_tick = 1'b0;
        checkOutput("ovr_set", 32'(overrun), 32'd1);
        waitDrain(1'b0);
        checkOutput("ovr_sticky", 32'(overrun), 32'd1);
        checkOutput("ovr_frame_idx", 32'(frame_idx), 32'd2);
        pulseStart();
        tickClk();
        checkOutput("busy_start_ovr", 32'(overrun), 32'd1);
        checkOutput("busy_start_idx", 32'(frame_idx), 32'd2);

        // Asynchronous reset mid-frame
        applyStimulus(8);
        for (w = 0; w < 10 && !bus.mem_rd; w++) tickClk();
        tickClk();
        #2 rst_n = 1'b0;
        #1 checkAllZero("rst_mid");
        expPixQ.delete();
        expAddrQ.delete();
        tickClk();
        rst_n = 1'b1;
        repeat (2) tickClk();
        checkOutput("rst_release_busy", 32'(busy), 32'd0);
        checkOutput("rst_release_rd", 32'(bus.mem_rd), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
